// File: rtl/msad_tracker.sv
// msad_tracker: two-stage registered minimum-SAD tracker for one motion-estimation
// search window. Stage 1 reduces each incoming batch to its minimum. Stage 2 folds
// that minimum into the running best. A one-cycle strobe then publishes the winning
// SAD and its signed motion vector.
module msad_tracker #(
   parameter int unsigned PIXELS_IN_BATCH = 16,
   parameter int unsigned SAD_BIT_WIDTH   = 14,
   parameter int unsigned NUM_BATCHES     = 16,
   parameter int unsigned MV_OFFSET       = 8,
   parameter int unsigned MV_BIT_WIDTH    = 5
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic                                     start_i,
   input  logic                                     batch_valid_i,
   input  logic [PIXELS_IN_BATCH*SAD_BIT_WIDTH-1:0] sad_batch_i,
   output logic                                     busy_o,
   output logic                                     result_valid_o,
   output logic [SAD_BIT_WIDTH-1:0]                 best_sad_o,
   output logic [MV_BIT_WIDTH-1:0]                  mv_x_o,
   output logic [MV_BIT_WIDTH-1:0]                  mv_y_o
);

   localparam int unsigned PixW = (PIXELS_IN_BATCH > 1) ? $clog2(PIXELS_IN_BATCH) : 1;
   localparam int unsigned CntW = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StSearch = 2'd1;
   localparam logic [1:0] StDrain  = 2'd2;
   localparam logic [1:0] StDone   = 2'd3;

   logic [1:0]               state_q, state_d;
   logic [CntW-1:0]          cnt_q, cnt_d;
   logic                     s1_valid_q, s1_valid_d;
   logic [SAD_BIT_WIDTH-1:0] s1_min_q, s1_min_d;
   logic [PixW-1:0]          s1_pix_q, s1_pix_d;
   logic [CntW-1:0]          s1_batch_q, s1_batch_d;
   logic [SAD_BIT_WIDTH-1:0] best_sad_q, best_sad_d;
   logic [PixW-1:0]          best_pix_q, best_pix_d;
   logic [CntW-1:0]          best_batch_q, best_batch_d;
   logic                     res_valid_q, res_valid_d;
   logic [SAD_BIT_WIDTH-1:0] res_sad_q, res_sad_d;
   logic [MV_BIT_WIDTH-1:0]  res_mv_x_q, res_mv_x_d;
   logic [MV_BIT_WIDTH-1:0]  res_mv_y_q, res_mv_y_d;

   logic                     accept;
   logic [SAD_BIT_WIDTH-1:0] batch_min;
   logic [PixW-1:0]          batch_idx;

   assign accept = (state_q == StSearch) && batch_valid_i;

   // Batch minimum; strict less-than keeps the lowest pixel index on ties.
   always_comb begin
      batch_min = sad_batch_i[SAD_BIT_WIDTH-1:0];
      batch_idx = '0;
      for (int p = 1; p < PIXELS_IN_BATCH; p++) begin
         if (sad_batch_i[p*SAD_BIT_WIDTH +: SAD_BIT_WIDTH] < batch_min) begin
            batch_min = sad_batch_i[p*SAD_BIT_WIDTH +: SAD_BIT_WIDTH];
            batch_idx = PixW'(p);
         end
      end
   end

   // Window sequencing and batch counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StSearch;
               cnt_d   = '0;
            end
         end
         StSearch: begin
            if (accept) begin
               // The counter stops on the last batch, so it never wraps within a window.
               if (cnt_q == CntW'(NUM_BATCHES - 1)) state_d = StDrain;
               else                                 cnt_d   = cnt_q + CntW'(1);
            end
         end
         StDrain: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Stage 1 captures the per-batch minimum; stage 2 folds it into the running best.
   always_comb begin
      s1_valid_d   = accept;
      s1_min_d     = s1_min_q;
      s1_pix_d     = s1_pix_q;
      s1_batch_d   = s1_batch_q;
      best_sad_d   = best_sad_q;
      best_pix_d   = best_pix_q;
      best_batch_d = best_batch_q;
      if (accept) begin
         s1_min_d   = batch_min;
         s1_pix_d   = batch_idx;
         s1_batch_d = cnt_q;
      end
      if ((state_q == StIdle) && start_i) begin
         best_sad_d   = '1;
         best_pix_d   = '0;
         best_batch_d = '0;
      end else if (s1_valid_q && (s1_min_q < best_sad_q)) begin
         // Strict less-than lets the earliest batch win ties across batches.
         best_sad_d   = s1_min_q;
         best_pix_d   = s1_pix_q;
         best_batch_d = s1_batch_q;
      end
   end

   // The result registers load only in DONE and hold their value until the next DONE.
   always_comb begin
      res_valid_d = (state_q == StDone);
      res_sad_d   = res_sad_q;
      res_mv_x_d  = res_mv_x_q;
      res_mv_y_d  = res_mv_y_q;
      if (state_q == StDone) begin
         res_sad_d  = best_sad_q;
         res_mv_x_d = MV_BIT_WIDTH'(32'(best_pix_q) - 32'(MV_OFFSET));
         res_mv_y_d = MV_BIT_WIDTH'(32'(best_batch_q) - 32'(MV_OFFSET));
      end
   end

   // All state registers; an asynchronous reset discards any partial window.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         s1_valid_q   <= 1'b0;
         s1_min_q     <= '0;
         s1_pix_q     <= '0;
         s1_batch_q   <= '0;
         best_sad_q   <= '1;
         best_pix_q   <= '0;
         best_batch_q <= '0;
         res_valid_q  <= 1'b0;
         res_sad_q    <= '0;
         res_mv_x_q   <= '0;
         res_mv_y_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         s1_valid_q   <= s1_valid_d;
         s1_min_q     <= s1_min_d;
         s1_pix_q     <= s1_pix_d;
         s1_batch_q   <= s1_batch_d;
         best_sad_q   <= best_sad_d;
         best_pix_q   <= best_pix_d;
         best_batch_q <= best_batch_d;
         res_valid_q  <= res_valid_d;
         res_sad_q    <= res_sad_d;
         res_mv_x_q   <= res_mv_x_d;
         res_mv_y_q   <= res_mv_y_d;
      end
   end

   assign busy_o         = (state_q != StIdle);
   assign result_valid_o = res_valid_q;
   assign best_sad_o     = res_sad_q;
   assign mv_x_o         = res_mv_x_q;
   assign mv_y_o         = res_mv_y_q;

endmodule

// File: tb/tb_msad_tracker.sv
// tb_msad_tracker: scenario tasks drive whole search windows into msad_tracker. Each
// result is compared with the first occurrence, in batch-then-pixel order, of the
// window's global minimum SAD.
module tb_msad_tracker;

   localparam int NP = 16;
   localparam int W  = 14;
   localparam int NB = 16;

   logic            clk = 1'b0;
   logic            rst_i;
   logic            start_i;
   logic            batch_valid_i;
   logic [NP*W-1:0] sad_batch_i;
   logic            busy_o;
   logic            result_valid_o;
   logic [W-1:0]    best_sad_o;
   logic [4:0]      mv_x_o;
   logic [4:0]      mv_y_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int strobe_cnt = 0;

   logic [W-1:0] win [NB][NP];

   msad_tracker dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .batch_valid_i  (batch_valid_i),
      .sad_batch_i    (sad_batch_i),
      .busy_o         (busy_o),
      .result_valid_o (result_valid_o),
      .best_sad_o     (best_sad_o),
      .mv_x_o         (mv_x_o),
      .mv_y_o         (mv_y_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (result_valid_o === 1'b1) strobe_cnt <= strobe_cnt + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic fill(input int lo, input int hi);
      for (int b = 0; b < NB; b++)
         for (int p = 0; p < NP; p++)
            win[b][p] = W'($urandom_range(hi, lo));
   endtask

   task automatic random_bus();
      for (int k = 0; k < (NP * W) / 32; k++) sad_batch_i[k*32 +: 32] = $urandom;
   endtask

   // Reference: the first occurrence, in batch-major order, of the window's global minimum.
   task automatic model(output int s, output int bx, output int by);
      int m;
      bit hit;
      m = win[0][0];
      for (int b = 0; b < NB; b++)
         for (int p = 0; p < NP; p++)
            if (int'(win[b][p]) < m) m = int'(win[b][p]);
      s = m; bx = 0; by = 0; hit = 0;
      for (int b = 0; b < NB; b++)
         for (int p = 0; p < NP; p++)
            if (!hit && int'(win[b][p]) == m) begin
               bx = p; by = b; hit = 1;
            end
   endtask

   // mode 0: contiguous, 1: valid toggles every cycle, 2: random gaps.
   // chained: entered on the strobe cycle of the previous window; earlier outputs must hold.
   task automatic run_window(input string name, input int mode, input bit chained,
                             input bit settle, input int abort_after);
      int b, e_edge, base, es, ebx, eby;
      bit found, valid, tog;
      logic [4:0] ex, ey, hx, hy;
      logic [W-1:0] hs;
      logic [NP*W-1:0] pk;
      model(es, ebx, eby);
      ex = 5'(ebx - 8);
      ey = 5'(eby - 8);
      hs = best_sad_o; hx = mv_x_o; hy = mv_y_o;
      e_edge = 0;
      if (!chained) begin @(posedge clk); #1; end
      start_i = 1'b1; batch_valid_i = 1'b0;
      @(posedge clk); #1;
      start_i = 1'b0;
      base = strobe_cnt;
      checks++;
      if (busy_o !== 1'b1) begin
         errors++; $display("FAIL %s busy_after_start got %b want 1", name, busy_o);
      end
      b = 0; tog = 1'b1;
      while (b < NB) begin
         valid = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(2, 0) != 0);
         tog = !tog;
         if (chained) begin
            checks++;
            if (best_sad_o !== hs || mv_x_o !== hx || mv_y_o !== hy || result_valid_o !== 1'b0) begin
               errors++;
               $display("FAIL %s hold got %0d/%0d/%0d v%b want %0d/%0d/%0d v0", name,
                        best_sad_o, $signed(mv_x_o), $signed(mv_y_o), result_valid_o,
                        hs, $signed(hx), $signed(hy));
            end
         end
         if (valid) begin
            for (int p = 0; p < NP; p++) pk[p*W +: W] = win[b][p];
            sad_batch_i = pk;
            batch_valid_i = 1'b1;
            if (b == NB - 1) e_edge = cyc + 1;
            b++;
         end else begin
            batch_valid_i = 1'b0;
            random_bus();
            start_i = (mode != 0) ? 1'($urandom_range(1, 0)) : 1'b0;
         end
         @(posedge clk); #1;
         start_i = 1'b0;
         if (abort_after >= 0 && b == abort_after + 1) begin
            #2 rst_i = 1'b1;
            #1;
            checks++;
            if (best_sad_o !== '0 || mv_x_o !== '0 || mv_y_o !== '0 || busy_o !== 1'b0 ||
                result_valid_o !== 1'b0) begin
               errors++;
               $display("FAIL %s async_reset got sad %0d x %0d y %0d busy %b v %b want all 0",
                        name, best_sad_o, mv_x_o, mv_y_o, busy_o, result_valid_o);
            end
            batch_valid_i = 1'b0;
            @(negedge clk);
            rst_i = 1'b0;
            base = strobe_cnt;
            repeat (6) @(negedge clk);
            checks++;
            if (strobe_cnt !== base || busy_o !== 1'b0) begin
               errors++;
               $display("FAIL %s no_strobe_after_abort got strobes %0d busy %b want 0 0",
                        name, strobe_cnt - base, busy_o);
            end
            return;
         end
      end
      // Batches presented after the last one must be ignored.
      batch_valid_i = (mode == 0);
      sad_batch_i = '0;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         @(negedge clk);
         if (result_valid_o === 1'b1) found = 1'b1;
         else if (chained) begin
            checks++;
            if (best_sad_o !== hs || mv_x_o !== hx || mv_y_o !== hy) begin
               errors++;
               $display("FAIL %s hold_drain got %0d want %0d", name, best_sad_o, hs);
            end
         end
      end
      batch_valid_i = 1'b0;
      checks++;
      if (!found) begin
         errors++; $display("FAIL %s strobe_timeout got none want strobe", name);
      end
      checks++;
      if (cyc != e_edge + 2) begin
         errors++; $display("FAIL %s latency got edge %0d want %0d", name, cyc, e_edge + 2);
      end
      checks++;
      if (best_sad_o !== W'(es)) begin
         errors++; $display("FAIL %s best_sad got %0d want %0d", name, best_sad_o, es);
      end
      checks++;
      if (mv_x_o !== ex) begin
         errors++;
         $display("FAIL %s mv_x got %0d want %0d", name, $signed(mv_x_o), $signed(ex));
      end
      checks++;
      if (mv_y_o !== ey) begin
         errors++;
         $display("FAIL %s mv_y got %0d want %0d", name, $signed(mv_y_o), $signed(ey));
      end
      if (settle) begin
         repeat (4) @(negedge clk);
         checks++;
         if (result_valid_o !== 1'b0 || busy_o !== 1'b0 || strobe_cnt !== base + 1) begin
            errors++;
            $display("FAIL %s one_strobe got v %b busy %b strobes %0d want 0 0 1", name,
                     result_valid_o, busy_o, strobe_cnt - base);
         end
         checks++;
         if (best_sad_o !== W'(es) || mv_x_o !== ex || mv_y_o !== ey) begin
            errors++;
            $display("FAIL %s held_result got %0d want %0d", name, best_sad_o, es);
         end
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; start_i = 1'b0; batch_valid_i = 1'b0; sad_batch_i = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || result_valid_o !== 1'b0 || best_sad_o !== '0 ||
          mv_x_o !== '0 || mv_y_o !== '0) begin
         errors++;
         $display("FAIL reset_state got busy %b v %b sad %0d x %0d y %0d want all 0",
                  busy_o, result_valid_o, best_sad_o, mv_x_o, mv_y_o);
      end
      rst_i = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || result_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got busy %b v %b want 0 0", busy_o, result_valid_o);
      end
   endtask

   task automatic test_single_min();
      // Batches offered while idle must not be counted.
      @(posedge clk); #1;
      batch_valid_i = 1'b1; sad_batch_i = '0;
      repeat (3) @(posedge clk);
      #1 batch_valid_i = 1'b0;
      fill(100, 100);
      win[5][3] = 7;
      run_window("single_min", 0, 1'b0, 1'b1, -1);
   endtask

   task automatic test_ties();
      fill(16'h3FFF, 16'h3FFF);
      win[2][4] = 0; win[2][9] = 0; win[10][1] = 0;
      run_window("ties", 0, 1'b0, 1'b1, -1);
   endtask

   task automatic test_gapped();
      fill(1000, 1000);
      win[15][15] = 50;
      run_window("gapped", 1, 1'b0, 1'b1, -1);
   endtask

   task automatic test_all_max();
      fill(16'h3FFF, 16'h3FFF);
      run_window("all_max", 0, 1'b0, 1'b1, -1);
   endtask

   task automatic test_abort_restart();
      fill(100, 100);
      win[4][2] = 3;
      run_window("abort", 0, 1'b0, 1'b0, 9);
      fill(21, 16'h3FFF);
      win[0][8] = 20;
      run_window("restart", 2, 1'b0, 1'b1, -1);
   endtask

   task automatic test_back_to_back();
      fill(0, 300);
      run_window("b2b_first", 0, 1'b0, 1'b0, -1);
      fill(0, 300);
      run_window("b2b_second", 2, 1'b1, 1'b1, -1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 4; n++) begin
         fill(0, 40 + n * 60);
         run_window("random", 2, 1'b0, 1'b1, -1);
      end
   endtask

   initial begin
      test_reset();
      test_single_min();
      test_ties();
      test_gapped();
      test_all_max();
      test_abort_restart();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
